// File: rtl/mpsoc_dbg_or1k_burst_ctrl_if.sv
// mpsoc_dbg_or1k_burst_ctrl_if: command, write/read stream and BIU handshake bundle for the burst controller.
// Signal suffixes are from the controller's point of view; master = controller, slave = its environment.
interface mpsoc_dbg_or1k_burst_ctrl_if #(
    parameter int CPU_ADDR_WIDTH = 32,
    parameter int CPU_DATA_WIDTH = 32,
    parameter int COUNT_WIDTH    = 16
);
    logic                      cmd_valid_i;
    logic                      cmd_ready_o;
    logic [3:0]                cmd_cpu_i;
    logic [CPU_ADDR_WIDTH-1:0] cmd_addr_i;
    logic [COUNT_WIDTH-1:0]    cmd_count_i;
    logic                      cmd_rd_wrn_i;
    logic                      wr_valid_i;
    logic                      wr_ready_o;
    logic [CPU_DATA_WIDTH-1:0] wr_data_i;
    logic                      rd_valid_o;
    logic                      rd_ready_i;
    logic [CPU_DATA_WIDTH-1:0] rd_data_o;
    logic [3:0]                biu_cpu_select_o;
    logic [CPU_ADDR_WIDTH-1:0] biu_addr_o;
    logic [CPU_DATA_WIDTH-1:0] biu_data_o;
    logic                      biu_rd_wrn_o;
    logic                      biu_strobe_o;
    logic [CPU_DATA_WIDTH-1:0] biu_data_i;
    logic                      biu_rdy_i;
    logic                      busy_o;
    logic                      done_o;
    logic                      err_o;

    modport master (
        input  cmd_valid_i, cmd_cpu_i, cmd_addr_i, cmd_count_i, cmd_rd_wrn_i,
        input  wr_valid_i, wr_data_i, rd_ready_i, biu_data_i, biu_rdy_i,
        output cmd_ready_o, wr_ready_o, rd_valid_o, rd_data_o,
        output biu_cpu_select_o, biu_addr_o, biu_data_o, biu_rd_wrn_o, biu_strobe_o,
        output busy_o, done_o, err_o
    );

    modport slave (
        output cmd_valid_i, cmd_cpu_i, cmd_addr_i, cmd_count_i, cmd_rd_wrn_i,
        output wr_valid_i, wr_data_i, rd_ready_i, biu_data_i, biu_rdy_i,
        input  cmd_ready_o, wr_ready_o, rd_valid_o, rd_data_o,
        input  biu_cpu_select_o, biu_addr_o, biu_data_o, biu_rd_wrn_o, biu_strobe_o,
        input  busy_o, done_o, err_o
    );
endinterface

// File: rtl/mpsoc_dbg_or1k_burst_ctrl.sv
// mpsoc_dbg_or1k_burst_ctrl: TCK-domain sequencer turning one burst command into N single-word BIU SPR accesses.
// Optional abort input is enabled by defining MPSOC_DBG_BURST_ABORT_EN.
module mpsoc_dbg_or1k_burst_ctrl #(
    parameter int X              = 2,
    parameter int Y              = 2,
    parameter int Z              = 2,
    parameter int CORES_PER_TILE = 1,
    parameter int CPU_ADDR_WIDTH = 32,
    parameter int CPU_DATA_WIDTH = 32,
    parameter int COUNT_WIDTH    = 16,
    parameter int ADDR_STRIDE    = 1
) (
    input logic tck_i,
    input logic tlr_i,
`ifdef MPSOC_DBG_BURST_ABORT_EN
    input logic abort_i,
`endif
    mpsoc_dbg_or1k_burst_ctrl_if.master bus
);
    localparam int NUM_CPU = X * Y * Z * CORES_PER_TILE;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_DRAIN, S_NEXT} state_t;

    state_t                    state_q, state_d;
    logic [3:0]                cpu_q, cpu_d;
    logic [CPU_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [COUNT_WIDTH-1:0]    rem_q, rem_d;
    logic [CPU_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [CPU_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      rd_wrn_q, rd_wrn_d;
    logic                      abort_q, abort_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
    logic                      abort_w;
    logic                      bad_cpu;

`ifdef MPSOC_DBG_BURST_ABORT_EN
    assign abort_w = abort_i;
`else
    assign abort_w = 1'b0;
`endif

    assign bad_cpu = {28'd0, bus.cmd_cpu_i} >= 32'(NUM_CPU);

    always_ff @(posedge tck_i or posedge tlr_i) begin
        if (tlr_i) begin
            state_q  <= S_IDLE;
            cpu_q    <= '0;
            addr_q   <= '0;
            rem_q    <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rd_wrn_q <= 1'b0;
            abort_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cpu_q    <= cpu_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rd_wrn_q <= rd_wrn_d;
            abort_q  <= abort_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // done/err are registered, so every completion pulse lands one cycle after the deciding state
    always_comb begin
        state_d  = state_q;
        cpu_d    = cpu_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rd_wrn_d = rd_wrn_q;
        abort_d  = abort_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (bus.cmd_valid_i) begin
                    cpu_d    = bus.cmd_cpu_i;
                    addr_d   = bus.cmd_addr_i;
                    rem_d    = bus.cmd_count_i;
                    rd_wrn_d = bus.cmd_rd_wrn_i;
                    if (bad_cpu) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else if (bus.cmd_count_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = bus.cmd_rd_wrn_i ? S_ISSUE : S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (abort_w) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else if (bus.wr_valid_i) begin
                    wdata_d = bus.wr_data_i;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                abort_d = abort_q | abort_w;
                state_d = bus.biu_rdy_i ? S_WAIT : S_ISSUE;
            end
            S_WAIT: begin
                abort_d = abort_q | abort_w;
                // an aborted access still runs to its BIU acknowledge; its read data is dropped
                if (bus.biu_rdy_i) begin
                    if (abort_q | abort_w) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (rd_wrn_q) begin
                        rdata_d = bus.biu_data_i;
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_NEXT;
                    end
                end
            end
            S_DRAIN: begin
                if (abort_w) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else if (bus.rd_ready_i) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (abort_w) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    addr_d = addr_q + CPU_ADDR_WIDTH'(ADDR_STRIDE);
                    rem_d  = rem_q - COUNT_WIDTH'(1);
                    if (rem_q == COUNT_WIDTH'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = rd_wrn_q ? S_ISSUE : S_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.cmd_ready_o      = state_q == S_IDLE;
    assign bus.wr_ready_o       = state_q == S_FETCH;
    assign bus.rd_valid_o       = state_q == S_DRAIN;
    assign bus.rd_data_o        = rdata_q;
    assign bus.biu_strobe_o     = (state_q == S_ISSUE) && bus.biu_rdy_i;
    assign bus.biu_cpu_select_o = cpu_q;
    assign bus.biu_addr_o       = addr_q;
    assign bus.biu_data_o       = wdata_q;
    assign bus.biu_rd_wrn_o     = rd_wrn_q;
    assign bus.busy_o           = state_q != S_IDLE;
    assign bus.done_o           = done_q;
    assign bus.err_o            = err_q;
endmodule

// File: tb/tb_mpsoc_dbg_or1k_burst_ctrl.sv
// tb_mpsoc_dbg_or1k_burst_ctrl: table-driven and randomized bursts against a BIU model and an address/data reference model.
module tb_mpsoc_dbg_or1k_burst_ctrl;
    localparam int AW = 32, DW = 32, CW = 16, STRIDE = 1, NCPU = 8;

    logic tck = 1'b0;
    logic tlr = 1'b1;
`ifdef MPSOC_DBG_BURST_ABORT_EN
    logic abort = 1'b0;
`endif
    int n_chk = 0;
    int n_fail = 0;
    int biu_lat = 2;
    int bcnt;
    logic [31:0] baddr;
    logic prev_s = 1'b0;

    typedef struct {
        logic [3:0]  cpu;
        logic [31:0] addr;
        logic        rd;
        logic [31:0] data;
    } acc_t;
    acc_t acc_q[$];

    typedef struct {
        logic        rd;
        logic [3:0]  cpu;
        logic [31:0] addr;
        logic [15:0] cnt;
        int          lat;
        int          stall;
        logic [31:0] wd0;
        logic [31:0] wd1;
        logic        exp_err;
    } vec_t;
    vec_t vt[8];

    mpsoc_dbg_or1k_burst_ctrl_if #(.CPU_ADDR_WIDTH(AW), .CPU_DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus();

    mpsoc_dbg_or1k_burst_ctrl #(
        .X(2), .Y(2), .Z(2), .CORES_PER_TILE(1),
        .CPU_ADDR_WIDTH(AW), .CPU_DATA_WIDTH(DW), .COUNT_WIDTH(CW), .ADDR_STRIDE(STRIDE)
    ) dut (
        .tck_i(tck),
        .tlr_i(tlr),
`ifdef MPSOC_DBG_BURST_ABORT_EN
        .abort_i(abort),
`endif
        .bus(bus)
    );

    always #5 tck = ~tck;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // BIU model: rdy drops on the strobe edge, returns after biu_lat+1 cycles with mem(addr)
    always @(posedge tck or posedge tlr) begin
        if (tlr) begin
            bus.biu_rdy_i  <= 1'b1;
            bus.biu_data_i <= '0;
            bcnt           <= 0;
        end else if (bus.biu_strobe_o && bus.biu_rdy_i) begin
            bus.biu_rdy_i <= 1'b0;
            bcnt          <= biu_lat;
            baddr         <= bus.biu_addr_o;
            acc_q.push_back('{bus.biu_cpu_select_o, bus.biu_addr_o, bus.biu_rd_wrn_o, bus.biu_data_o});
        end else if (!bus.biu_rdy_i) begin
            if (bcnt == 0) begin
                bus.biu_rdy_i  <= 1'b1;
                bus.biu_data_i <= mem(baddr);
            end else begin
                bcnt <= bcnt - 1;
            end
        end
    end

    always @(negedge tck) begin
        if (!tlr) begin
            if (bus.biu_strobe_o) begin
                chk("strobe_without_rdy", {63'd0, bus.biu_rdy_i}, 64'd1);
                chk("strobe_twice", {63'd0, prev_s}, 64'd0);
            end
            if (!bus.biu_rdy_i && acc_q.size() > 0) begin
                chk("biu_addr_stable", {32'd0, bus.biu_addr_o}, {32'd0, acc_q[$].addr});
                chk("biu_data_stable", {32'd0, bus.biu_data_o}, {32'd0, acc_q[$].data});
                chk("biu_rdwrn_stable", {63'd0, bus.biu_rd_wrn_o}, {63'd0, acc_q[$].rd});
            end
            prev_s <= bus.biu_strobe_o;
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_cmd_ready"}, {63'd0, bus.cmd_ready_o}, 64'd1);
        chk({tag, "_busy"}, {63'd0, bus.busy_o}, 64'd0);
        chk({tag, "_done_err"}, {62'd0, bus.done_o, bus.err_o}, 64'd0);
        chk({tag, "_strobe"}, {63'd0, bus.biu_strobe_o}, 64'd0);
        chk({tag, "_valids"}, {62'd0, bus.rd_valid_o, bus.wr_ready_o}, 64'd0);
        chk({tag, "_biu_addr"}, {32'd0, bus.biu_addr_o}, 64'd0);
        chk({tag, "_biu_data"}, {32'd0, bus.biu_data_o}, 64'd0);
        chk({tag, "_biu_sel_rw"}, {59'd0, bus.biu_cpu_select_o, bus.biu_rd_wrn_o}, 64'd0);
        chk({tag, "_rd_data"}, {32'd0, bus.rd_data_o}, 64'd0);
    endtask

    function automatic int next_stall(input bit rnd, input int stall);
        return rnd ? int'($urandom_range(0, 3)) : stall;
    endfunction

    task automatic run_burst(input logic rd, input logic [3:0] cpu, input logic [31:0] addr,
                             input logic [15:0] cnt, input int lat, input int stall, input bit rnd,
                             input logic [31:0] wd0, input logic [31:0] wd1, input logic exp_err);
        logic [31:0] wq[$];
        logic [31:0] rq[$];
        logic [31:0] held, ea;
        int n_exp, dones, errs, sc, st, wi, cyc;
        bit hold_v;
        dones = 0; errs = 0; sc = 0; wi = 0; hold_v = 1'b0; held = '0;
        n_exp = (exp_err || cnt == 0) ? 0 : int'(cnt);
        for (int i = 0; i < int'(cnt); i++) wq.push_back(i == 0 ? wd0 : i == 1 ? wd1 : $urandom);
        acc_q.delete();
        biu_lat = lat;
        st = next_stall(rnd, stall);
        @(negedge tck);
        chk("cmd_ready_idle", {63'd0, bus.cmd_ready_o}, 64'd1);
        bus.cmd_valid_i  = 1'b1;
        bus.cmd_cpu_i    = cpu;
        bus.cmd_addr_i   = addr;
        bus.cmd_count_i  = cnt;
        bus.cmd_rd_wrn_i = rd;
        @(negedge tck);
        bus.cmd_valid_i = 1'b0;
        for (cyc = 0; cyc < 2000; cyc++) begin
            if (bus.done_o) dones++;
            if (bus.err_o) begin
                errs++;
                chk("err_with_done", {63'd0, bus.done_o}, 64'd1);
            end
            if (bus.biu_strobe_o && !rd) chk("wr_word_before_strobe", 64'(wi), 64'(acc_q.size() + 1));
            bus.wr_valid_i = 1'b0;
            bus.rd_ready_i = 1'b0;
            if (bus.wr_ready_o) begin
                if (sc < st) sc++;
                else begin
                    bus.wr_valid_i = 1'b1;
                    bus.wr_data_i  = wi < wq.size() ? wq[wi] : '0;
                    wi++;
                    sc = 0;
                    st = next_stall(rnd, stall);
                end
            end
            if (bus.rd_valid_o) begin
                chk("drain_no_strobe", {63'd0, bus.biu_strobe_o}, 64'd0);
                if (hold_v) chk("rd_data_hold", {32'd0, bus.rd_data_o}, {32'd0, held});
                held = bus.rd_data_o;
                hold_v = 1'b1;
                if (sc < st) sc++;
                else begin
                    bus.rd_ready_i = 1'b1;
                    rq.push_back(bus.rd_data_o);
                    hold_v = 1'b0;
                    sc = 0;
                    st = next_stall(rnd, stall);
                end
            end
            if (dones > 0) break;
            @(negedge tck);
        end
        chk("burst_timeout", {63'd0, cyc < 2000}, 64'd1);
        repeat (4) begin
            @(negedge tck);
            bus.wr_valid_i = 1'b0;
            bus.rd_ready_i = 1'b0;
            if (bus.done_o) dones++;
            if (bus.err_o) errs++;
        end
        chk("access_count", 64'(acc_q.size()), 64'(n_exp));
        chk("done_count", 64'(dones), 64'd1);
        chk("err_count", 64'(errs), {63'd0, exp_err});
        chk("busy_end", {63'd0, bus.busy_o}, 64'd0);
        for (int i = 0; i < acc_q.size() && i < n_exp; i++) begin
            ea = addr + 32'(i * STRIDE);
            chk("acc_addr", {32'd0, acc_q[i].addr}, {32'd0, ea});
            chk("acc_cpu", {60'd0, acc_q[i].cpu}, {60'd0, cpu});
            chk("acc_rd_wrn", {63'd0, acc_q[i].rd}, {63'd0, rd});
            if (!rd) chk("acc_wdata", {32'd0, acc_q[i].data}, {32'd0, wq[i]});
        end
        if (rd) begin
            chk("rd_count", 64'(rq.size()), 64'(n_exp));
            for (int i = 0; i < rq.size() && i < n_exp; i++)
                chk("rd_data", {32'd0, rq[i]}, {32'd0, mem(addr + 32'(i * STRIDE))});
        end else begin
            chk("wr_count", 64'(wi), 64'(n_exp));
        end
    endtask

    logic        r_rd;
    logic [3:0]  r_cpu;
    logic [31:0] r_addr;
    logic [15:0] r_cnt;

    initial begin
        vt[0] = '{1'b1, 4'd0,  32'h0000_0100, 16'd3, 5, 0,  32'h0,      32'h0,      1'b0};
        vt[1] = '{1'b0, 4'd1,  32'h0000_0200, 16'd2, 2, 4,  32'hDEAD,   32'hBEEF,   1'b0};
        vt[2] = '{1'b1, 4'd8,  32'h0000_0300, 16'd1, 1, 0,  32'h0,      32'h0,      1'b1};
        vt[3] = '{1'b0, 4'd15, 32'h0000_0000, 16'd5, 1, 0,  32'h1,      32'h2,      1'b1};
        vt[4] = '{1'b0, 4'd3,  32'hFFFF_FFFF, 16'd2, 1, 1,  32'h1234,   32'h5678,   1'b0};
        vt[5] = '{1'b1, 4'd2,  32'h0000_0040, 16'd0, 1, 0,  32'h0,      32'h0,      1'b0};
        vt[6] = '{1'b1, 4'd7,  32'hFFFF_FFFF, 16'd2, 0, 10, 32'h0,      32'h0,      1'b0};
        vt[7] = '{1'b0, 4'd5,  32'h0000_0080, 16'd0, 1, 0,  32'hA5A5,   32'h5A5A,   1'b0};
        bus.cmd_valid_i  = 1'b0;
        bus.cmd_cpu_i    = '0;
        bus.cmd_addr_i   = '0;
        bus.cmd_count_i  = '0;
        bus.cmd_rd_wrn_i = 1'b0;
        bus.wr_valid_i   = 1'b0;
        bus.wr_data_i    = '0;
        bus.rd_ready_i   = 1'b0;
        repeat (2) @(negedge tck);
        chk_reset("reset");
        tlr = 1'b0;

        foreach (vt[i])
            run_burst(vt[i].rd, vt[i].cpu, vt[i].addr, vt[i].cnt, vt[i].lat, vt[i].stall, 1'b0,
                      vt[i].wd0, vt[i].wd1, vt[i].exp_err);

        // reset while an access is outstanding at the BIU
        acc_q.delete();
        biu_lat = 20;
        @(negedge tck);
        bus.cmd_valid_i  = 1'b1;
        bus.cmd_cpu_i    = 4'd0;
        bus.cmd_addr_i   = 32'h500;
        bus.cmd_count_i  = 16'd4;
        bus.cmd_rd_wrn_i = 1'b1;
        @(negedge tck);
        bus.cmd_valid_i = 1'b0;
        repeat (3) @(negedge tck);
        chk("mid_busy", {63'd0, bus.busy_o}, 64'd1);
        tlr = 1'b1;
        #1;
        chk_reset("midrst");
        @(negedge tck);
        tlr = 1'b0;
        run_burst(1'b1, 4'd1, 32'h600, 16'd2, 1, 0, 1'b0, 32'h0, 32'h0, 1'b0);

`ifdef MPSOC_DBG_BURST_ABORT_EN
        acc_q.delete();
        biu_lat = 6;
        @(negedge tck);
        bus.cmd_valid_i  = 1'b1;
        bus.cmd_cpu_i    = 4'd0;
        bus.cmd_addr_i   = 32'h700;
        bus.cmd_count_i  = 16'd3;
        bus.cmd_rd_wrn_i = 1'b1;
        @(negedge tck);
        bus.cmd_valid_i = 1'b0;
        @(negedge tck);
        abort = 1'b1;
        @(negedge tck);
        abort = 1'b0;
        for (int c = 0; c < 30 && !bus.biu_rdy_i; c++) begin
            chk("abort_no_strobe", {63'd0, bus.biu_strobe_o}, 64'd0);
            chk("abort_no_done", {63'd0, bus.done_o}, 64'd0);
            @(negedge tck);
        end
        chk("abort_rdy_seen", {63'd0, bus.biu_rdy_i}, 64'd1);
        @(negedge tck);
        chk("abort_done_err", {62'd0, bus.done_o, bus.err_o}, 64'd3);
        chk("abort_idle", {62'd0, bus.busy_o, bus.rd_valid_o}, 64'd0);
        chk("abort_one_access", 64'(acc_q.size()), 64'd1);
`endif

        for (int k = 0; k < 14; k++) begin
            r_rd   = 1'($urandom_range(0, 1));
            r_cpu  = 4'($urandom_range(0, 9));
            r_addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
            r_cnt  = 16'($urandom_range(0, 5));
            run_burst(r_rd, r_cpu, r_addr, r_cnt, int'($urandom_range(0, 4)), 0, 1'b1,
                      $urandom, $urandom, {28'd0, r_cpu} >= NCPU);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
